// File: rtl/riscv_uop_pkg.sv
// Shared micro-op types for the write-back path: request payload and source ids.
package riscv_uop_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/wb_arbiter.sv
// Write-back port arbiter: ALU-first grant to the single ARF write port, 1-cycle registered output.
// Define WB_ARB_STARVE_EN to add the LSU anti-starvation override (starve_q vs STARVE_LIMIT).
module wb_arbiter
    import riscv_uop_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alu_wb_valid,
    input  logic [4:0]       i_alu_wb_rd,
    input  logic [31:0]      i_alu_wb_data,
    output logic             o_alu_wb_ready,
    input  logic             i_lsu_wb_valid,
    input  logic [4:0]       i_lsu_wb_rd,
    input  logic [31:0]      i_lsu_wb_data,
    output logic             o_lsu_wb_ready,
    input  logic             i_flush,
    output logic             o_wb_en,
    output logic [4:0]       o_wb_rd,
    output logic [31:0]      o_wb_data,
    output logic [CNT_W-1:0] o_conflict_cnt
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    wb_req_t    alu_req;
    wb_req_t    lsu_req;
    wb_req_t    sel_req;
    wb_req_t    wb_q;
    logic       wb_valid_q;
    logic       sel_src;
    logic       lsu_force;
    logic       accept;
    logic       both_valid;
    logic [CNT_W-1:0] conflict_q;

    assign alu_req = '{rd: i_alu_wb_rd, data: i_alu_wb_data};
    assign lsu_req = '{rd: i_lsu_wb_rd, data: i_lsu_wb_data};

`ifdef WB_ARB_STARVE_EN
    logic [3:0] starve_q;

    assign lsu_force = (starve_q == 4'(STARVE_LIMIT));

    // Counts consecutive cycles the LSU was valid but lost; any break in that run clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (i_flush || !i_lsu_wb_valid || o_lsu_wb_ready) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    assign lsu_force = 1'b0;
`endif

    always_comb begin
        sel_src = WB_SRC_ALU;
        if (i_lsu_wb_valid && (!i_alu_wb_valid || lsu_force)) begin
            sel_src = WB_SRC_LSU;
        end
    end

    assign o_alu_wb_ready = i_alu_wb_valid && (sel_src == WB_SRC_ALU) && !i_flush;
    assign o_lsu_wb_ready = i_lsu_wb_valid && (sel_src == WB_SRC_LSU) && !i_flush;
    assign accept         = o_alu_wb_ready || o_lsu_wb_ready;
    assign sel_req        = (sel_src == WB_SRC_LSU) ? lsu_req : alu_req;
    assign both_valid     = i_alu_wb_valid && i_lsu_wb_valid;

    // rd/data hold their last accepted value so only the valid bit needs to drop on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            wb_valid_q <= accept;
            if (accept) begin
                wb_q <= sel_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (both_valid && !i_flush && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    // Flush also masks a write already sitting in the output register.
    assign o_wb_en        = wb_valid_q && (wb_q.rd != 5'd0) && !i_flush;
    assign o_wb_rd        = wb_q.rd;
    assign o_wb_data      = wb_q.data;
    assign o_conflict_cnt = conflict_q;

endmodule
